uart_tx_emitter: RTL and testbench

//  Serial UART transmitter for the rv32 core's UART write port. Accepts bytes
//  as an optional-byte word {valid, data[7:0]}, buffers them in a small FIFO,
//  and shifts each out as an 8N1 frame (8 data bits, no parity, STOP_BITS stop

---
 rtl/uart_tx_emitter.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_emitter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_emitter.sv
// uart_tx_emitter
//   UART transmitter for the core's UART write port. Bytes arrive as
//   {valid, data[7:0]}, are queued in a small circular FIFO, and are sent as
//   8N1 frames (start, 8 data bits LSB first, STOP_BITS stop bits) on the TX pin.
//
// Ports
//   CLK            in   clock, all state changes on posedge
//   RST            in   synchronous reset, active-high
//   wr_opt_byte    in   [8]=valid, [7:0]=byte from the core
//   wr_ready       out  byte is accepted this cycle if valid (0 = core retries)
//   uart_line_out  out  serial TX line, idles high, registered
//   busy           out  frame in progress or FIFO non-empty
//   fifo_count     out  occupied FIFO entries (0..FIFO_DEPTH)
module uart_tx_emitter #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [8:0]                    wr_opt_byte,
    output logic                          wr_ready,
    output logic                          uart_line_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // state | meaning
    // IDLE  | line high, waiting for a queued byte
    // START | start bit (line low) for one bit time
    // DATA  | eight data bits, LSB first, one bit time each
    // STOP  | stop bit(s), line high; chains straight into START if queued

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int BAUD_W    = $clog2(STOP_CLKS);

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [BAUD_W-1:0]  baud_cnt, baud_nxt;
    logic [2:0]         bit_idx, bit_nxt;
    logic [7:0]         shift_reg, shift_nxt;
    logic               line_nxt;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop;

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign wr_ready   = !full && !RST;
    assign push       = wr_opt_byte[8] && wr_ready;
    assign busy       = (state != IDLE) || !empty;
    assign fifo_count = count;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift_reg;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    baud_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt == STOP_LAST) begin
                    baud_nxt = '0;
                    // Pop the next byte on the last stop cycle so frames abut.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Line level follows the state being entered, so the registered line
        // lines up with the state register with no extra cycle of lag.
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shift_nxt[0];
            default: line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= 3'd0;
            shift_reg     <= 8'h00;
            uart_line_out <= 1'b1;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            state         <= state_nxt;
            baud_cnt      <= baud_nxt;
            bit_idx       <= bit_nxt;
            shift_reg     <= shift_nxt;
            uart_line_out <= line_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; push is already blocked while RST is high.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_opt_byte[7:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_emitter.sv
module tb_uart_tx_emitter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int STOPB = 1;
    localparam int FLEN  = (9 + STOPB) * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [8:0] wr_opt_byte = 9'h000;
    logic       wr_ready, uart_line_out, busy;
    logic [2:0] fifo_count;

    logic [8:0] wr2 = 9'h000;
    logic       wr_ready2, line2, busy2;
    logic [2:0] count2;

    uart_tx_emitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOPB)) dut (
        .CLK(CLK), .RST(RST), .wr_opt_byte(wr_opt_byte), .wr_ready(wr_ready),
        .uart_line_out(uart_line_out), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_emitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .CLK(CLK), .RST(RST), .wr_opt_byte(wr2), .wr_ready(wr_ready2),
        .uart_line_out(line2), .busy(busy2), .fifo_count(count2)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame-level reference: queue of waiting bytes plus the frame on the wire.
    logic [7:0] m_q[$];
    logic [7:0] m_byte;
    bit         m_act = 0;
    int         m_off = 0;
    bit         m_started = 0;
    int         cyc = 0;

    function automatic int exp_line();
        int b;
        if (!m_act) return 1;
        b = m_off / CPB;
        if (b == 0) return 0;
        if (b <= 8) return m_byte[b-1] ? 1 : 0;
        return 1;
    endfunction

    // Receiver on the DUT line, sampling mid-bit.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         rx_on = 0;
    int         rx_off = 0;
    int         rx_start = 0;
    logic [7:0] rx_sh = 8'h00;

    int pk = 0;
    bit saw_nr = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_opt_byte = {1'b1, b};
        tick();
        wr_opt_byte = 9'h000;
    endtask

    logic [7:0] t3b [3];
    logic [7:0] t4b [6];

    initial begin
        int idx, budget, n, w;
        bit acc;
        t3b = '{8'hA3, 8'h00, 8'hFF};
        t4b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        fork
            forever begin : model_proc
                bit do_push, do_pop;
                @(posedge CLK);
                cyc++;
                if (RST) begin
                    m_q.delete();
                    m_act = 0;
                    m_off = 0;
                    m_started = 1;
                end else if (m_started) begin
                    do_push = wr_opt_byte[8] && (m_q.size() < DEPTH);
                    do_pop  = (m_q.size() > 0) && (!m_act || m_off == FLEN - 1);
                    if (m_act) begin
                        m_off++;
                        if (m_off == FLEN) m_act = 0;
                    end
                    if (do_pop) begin
                        m_byte = m_q.pop_front();
                        m_act  = 1;
                        m_off  = 0;
                    end
                    if (do_push) m_q.push_back(wr_opt_byte[7:0]);
                end
            end
            forever begin : compare_proc
                @(negedge CLK);
                if (m_started) begin
                    chk("line", 32'(uart_line_out), exp_line());
                    chk("busy", 32'(busy), (m_act || m_q.size() > 0) ? 1 : 0);
                    chk("fifo_count", 32'(fifo_count), m_q.size());
                    chk("wr_ready", 32'(wr_ready), (!RST && m_q.size() < DEPTH) ? 1 : 0);
                    if (int'(fifo_count) > pk) pk = int'(fifo_count);
                    if (!RST && !wr_ready) saw_nr = 1;
                end
            end
            forever begin : rx_proc
                @(negedge CLK);
                if (RST) begin
                    rx_on = 0;
                end else if (!rx_on) begin
                    if (uart_line_out === 1'b0) begin
                        rx_on    = 1;
                        rx_off   = 0;
                        rx_start = cyc;
                    end
                end else begin
                    rx_off++;
                    if (rx_off % CPB == 2 && rx_off / CPB >= 1 && rx_off / CPB <= 8)
                        rx_sh[rx_off / CPB - 1] = uart_line_out;
                    if (rx_off == 9 * CPB + 2) begin
                        rx_q.push_back(rx_sh);
                        rx_t.push_back(rx_start);
                        rx_on = 0;
                    end
                end
            end
        join_none

        // 1: reset held, wr_ready low throughout
        repeat (3) begin
            @(negedge CLK);
            chk("t1_rst_wr_ready", 32'(wr_ready), 0);
        end
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("t1_line", 32'(uart_line_out), 1);
        chk("t1_wr_ready", 32'(wr_ready), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_count", 32'(fifo_count), 0);

        // 2: single 0x55 frame, start bit two cycles after the push edge
        rx_q.delete(); rx_t.delete();
        tick();
        push_byte(8'h55);
        tick();
        for (int off = 0; off < FLEN; off++) begin
            @(negedge CLK);
            if (off % CPB == 2) chk("t2_line_bit", 32'(uart_line_out), (off / CPB) % 2);
        end
        @(negedge CLK);
        chk("t2_busy_after", 32'(busy), 0);
        chk("t2_rx_n", 32'(rx_q.size()), 1);
        if (rx_q.size() >= 1) chk("t2_rx_byte", 32'(rx_q[0]), 8'h55);

        // 3: three back-to-back bytes, 40-cycle pitch, count peaks at 2
        rx_q.delete(); rx_t.delete(); pk = 0;
        tick();
        push_byte(8'hA3);
        push_byte(8'h00);
        push_byte(8'hFF);
        repeat (130) tick();
        chk("t3_rx_n", 32'(rx_q.size()), 3);
        if (rx_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("t3_rx_byte", 32'(rx_q[i]), int'(t3b[i]));
            chk("t3_pitch1", 32'(rx_t[1] - rx_t[0]), 40);
            chk("t3_pitch2", 32'(rx_t[2] - rx_t[1]), 40);
        end
        chk("t3_peak", 32'(pk), 2);

        // 4: hold valid with six bytes, back-pressure at four queued
        rx_q.delete(); rx_t.delete(); pk = 0; saw_nr = 0;
        tick();
        idx = 0; budget = 0;
        while (idx < 6 && budget < 500) begin
            wr_opt_byte = {1'b1, t4b[idx]};
            @(negedge CLK);
            acc = wr_ready;
            @(posedge CLK);
            #1;
            if (acc) idx++;
            budget++;
        end
        wr_opt_byte = 9'h000;
        chk("t4_accepted", 32'(idx), 6);
        budget = 0;
        while (rx_q.size() < 6 && budget < 400) begin
            tick();
            budget++;
        end
        chk("t4_rx_n", 32'(rx_q.size()), 6);
        if (rx_q.size() == 6)
            for (int i = 0; i < 6; i++) chk("t4_rx_byte", 32'(rx_q[i]), int'(t4b[i]));
        chk("t4_peak", 32'(pk), 4);
        chk("t4_backpressure", 32'(saw_nr), 1);
        repeat (5) tick();

        // 5: data without valid is ignored
        wr_opt_byte = 9'h0FF;
        repeat (20) begin
            @(negedge CLK);
            chk("t5_line", 32'(uart_line_out), 1);
            chk("t5_count", 32'(fifo_count), 0);
            @(posedge CLK);
            #1;
        end
        wr_opt_byte = 9'h000;

        // 6: reset during data bit 3 of 0xC3 with two bytes queued
        rx_q.delete(); rx_t.delete();
        tick();
        push_byte(8'hC3);
        push_byte(8'h5A);
        push_byte(8'h96);
        repeat (15) tick();
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_bit3", 32'(uart_line_out), 0);
        chk("t6_queued", 32'(fifo_count), 2);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("t6_line_after", 32'(uart_line_out), 1);
        chk("t6_count_after", 32'(fifo_count), 0);
        chk("t6_busy_after", 32'(busy), 0);
        repeat (60) begin
            @(negedge CLK);
            chk("t6_line_quiet", 32'(uart_line_out), 1);
        end
        chk("t6_rx_n", 32'(rx_q.size()), 0);

        // 6b: two stop bits -> stop phase is 8 cycles high between frames
        tick();
        wr2 = 9'h100;
        tick();
        tick();
        wr2 = 9'h000;
        w = 0;
        @(negedge CLK);
        while (line2 !== 1'b0 && w < 20) begin
            w++;
            @(negedge CLK);
        end
        chk("t7_start_seen", 32'(w < 20), 1);
        n = 0;
        while (line2 === 1'b0 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("t7_low_len", 32'(n), 36);
        n = 0;
        while (line2 === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("t7_stop_len", 32'(n), 8);
        repeat (60) @(negedge CLK);
        chk("t7_busy_end", 32'(busy2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
